// File: rtl/routex_sink_parser.sv
// routex_sink_parser
//   Terminating endpoint of the routex network. Each accepted beat of LANES
//   words is split into route/header/length words (header section) and
//   payload words, and the frame's destination is taken from its first
//   route word. All outputs are registered, one cycle after the beat.
// Ports
//   CLK, RST          clock, asynchronous active-low reset
//   D, D_VALID        beat data (lane 0 = first word) and beat qualifier
//   DEST, DEST_VALID  first route word value of the frame, update pulse
//   SOF, EOF, FRAME   first / last / any beat of a frame
//   HDR_VALID         per-lane header-section flag (route, header, length)
//   PLD_VALID         per-lane payload flag

// Per-lane tag decode: splits a word into tag class and value.
module routex_lane_dec #(
  parameter int W = 64
) (
  input  logic [W-1:0] word,
  output logic         is_route,
  output logic         is_len,
  output logic [W-9:0] val
);
  logic [7:0] tag;
  assign tag      = word[W-1:W-8];
  assign val      = word[W-9:0];
  assign is_route = (tag == 8'h02);
  assign is_len   = (tag == 8'h00);
endmodule

module routex_sink_parser #(
  parameter int LANES = 8,
  parameter int W     = 64,
  parameter int LENW  = 16
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [LANES-1:0][W-1:0]   D,
  input  logic                      D_VALID,
  output logic [W-9:0]              DEST,
  output logic                      DEST_VALID,
  output logic                      SOF,
  output logic                      EOF,
  output logic                      FRAME,
  output logic [LANES-1:0]          HDR_VALID,
  output logic [LANES-1:0]          PLD_VALID
);

  typedef enum logic [1:0] {HEAD_IDLE, HEAD, PLD} state_e;

  logic [LANES-1:0]         is_route, is_len;
  logic [LANES-1:0][W-9:0]  val;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    routex_lane_dec #(.W(W)) u_dec (
      .word     (D[g]),
      .is_route (is_route[g]),
      .is_len   (is_len[g]),
      .val      (val[g])
    );
  end

  state_e            state_q, state_d;
  logic [LENW-1:0]   rem_q, rem_d;
  logic              got_q, got_d;     // first route word of this frame seen
  logic [W-9:0]      dest_q, dest_d;
  logic              dv_q, dv_d;
  logic              sof_q, sof_d;
  logic              eof_q, eof_d;
  logic              frame_q, frame_d;
  logic [LANES-1:0]  hdr_q, hdr_d;
  logic [LANES-1:0]  pld_q, pld_d;

  // Lane walk scratch: classification of a lane depends on every lower lane.
  logic              in_hdr;
  logic              done;
  logic              got;
  logic [LENW-1:0]   cnt;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    got_d   = got_q;
    dest_d  = dest_q;
    dv_d    = 1'b0;
    sof_d   = 1'b0;
    eof_d   = 1'b0;
    frame_d = 1'b0;
    hdr_d   = '0;
    pld_d   = '0;
    in_hdr  = (state_q != PLD);
    done    = 1'b0;
    got     = got_q;
    cnt     = rem_q;
    if (D_VALID) begin
      frame_d = 1'b1;
      // Every valid beat in idle opens a new frame at lane 0.
      if (state_q == HEAD_IDLE) begin
        sof_d = 1'b1;
        got   = 1'b0;
      end
      for (int i = 0; i < LANES; i++) begin
        if (!done) begin
          if (in_hdr) begin
            hdr_d[i] = 1'b1;
            if (is_route[i] && !got) begin
              got    = 1'b1;
              dest_d = val[i];
              dv_d   = 1'b1;
            end
            if (is_len[i]) begin
              in_hdr = 1'b0;
              cnt    = val[i][LENW-1:0];
              if (cnt == '0) done = 1'b1;
            end
          end else if (cnt != '0) begin
            pld_d[i] = 1'b1;
            cnt      = cnt - LENW'(1);
            if (cnt == '0) done = 1'b1;
          end
        end
      end
      // Lanes after the frame's last word are dropped; next frame starts
      // at lane 0 of the next valid beat.
      eof_d   = done;
      got_d   = got;
      rem_d   = done ? '0 : cnt;
      state_d = done ? HEAD_IDLE : (in_hdr ? HEAD : PLD);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= HEAD_IDLE;
      rem_q   <= '0;
      got_q   <= 1'b0;
      dest_q  <= '0;
      dv_q    <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      frame_q <= 1'b0;
      hdr_q   <= '0;
      pld_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      got_q   <= got_d;
      dest_q  <= dest_d;
      dv_q    <= dv_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
      frame_q <= frame_d;
      hdr_q   <= hdr_d;
      pld_q   <= pld_d;
    end
  end

  assign DEST       = dest_q;
  assign DEST_VALID = dv_q;
  assign SOF        = sof_q;
  assign EOF        = eof_q;
  assign FRAME      = frame_q;
  assign HDR_VALID  = hdr_q;
  assign PLD_VALID  = pld_q;

endmodule

// File: tb/tb_routex_sink_parser.sv
module tb_routex_sink_parser;
  localparam int LANES = 8;
  localparam int W     = 64;

  typedef logic [LANES-1:0][W-1:0] beat_t;

  logic                     clk, rst_n;
  beat_t                    d;
  logic                     d_valid;
  logic [W-9:0]             dest;
  logic                     dest_valid, sof, eof, frame;
  logic [LANES-1:0]         hdr_valid, pld_valid;

  int checks = 0;
  int errors = 0;

  routex_sink_parser #(.LANES(LANES), .W(W), .LENW(16)) dut (
    .CLK(clk), .RST(rst_n), .D(d), .D_VALID(d_valid),
    .DEST(dest), .DEST_VALID(dest_valid), .SOF(sof), .EOF(eof),
    .FRAME(frame), .HDR_VALID(hdr_valid), .PLD_VALID(pld_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] wd(input logic [7:0] tag, input logic [55:0] v);
    return {tag, v};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Frame-level view: a frame is open or not; while open we are either still
  // reading the header section or counting down the payload words left.
  bit          m_open = 0, m_in_hdr = 0, m_have_dest = 0;
  int          m_left = 0;
  logic [55:0] m_dest = '0;
  logic        e_dv, e_sof, e_eof, e_frame;
  logic [7:0]  e_hdr, e_pld;

  task automatic model_beat(input beat_t b);
    e_frame = 1; e_sof = 0; e_eof = 0; e_dv = 0; e_hdr = 0; e_pld = 0;
    if (!m_open) begin
      m_open = 1; m_in_hdr = 1; m_have_dest = 0; e_sof = 1;
    end
    for (int i = 0; i < LANES; i++) begin
      logic [7:0]  tag;
      logic [55:0] v;
      if (!m_open) break;
      tag = b[i][63:56];
      v   = b[i][55:0];
      if (m_in_hdr) begin
        e_hdr[i] = 1;
        if (tag == 8'h02 && !m_have_dest) begin
          m_have_dest = 1; m_dest = v; e_dv = 1;
        end
        if (tag == 8'h00) begin
          m_in_hdr = 0;
          m_left = int'(v % 65536);
          if (m_left == 0) begin e_eof = 1; m_open = 0; end
        end
      end else begin
        e_pld[i] = 1;
        m_left--;
        if (m_left == 0) begin e_eof = 1; m_open = 0; end
      end
    end
  endtask

  // Compare process: checks every cycle's registered outputs.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_open = 0; m_dest = '0; m_left = 0;
      e_frame = 0; e_sof = 0; e_eof = 0; e_dv = 0; e_hdr = 0; e_pld = 0;
    end else if (d_valid) begin
      model_beat(d);
    end else begin
      e_frame = 0; e_sof = 0; e_eof = 0; e_dv = 0; e_hdr = 0; e_pld = 0;
    end
    #1;
    chk("m_dest",  64'(dest),       64'(m_dest));
    chk("m_dv",    64'(dest_valid), 64'(e_dv));
    chk("m_sof",   64'(sof),        64'(e_sof));
    chk("m_eof",   64'(eof),        64'(e_eof));
    chk("m_frame", 64'(frame),      64'(e_frame));
    chk("m_hdr",   64'(hdr_valid),  64'(e_hdr));
    chk("m_pld",   64'(pld_valid),  64'(e_pld));
  end

  // ---------------- stimulus ----------------
  task automatic send(input beat_t b, input logic v);
    @(negedge clk);
    d = b; d_valid = v;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    beat_t z;
    z = '0;
    for (int k = 0; k < n; k++) send(z, 1'b0);
  endtask

  // Standard 3-beat header: 3 route + 5 header, 8 header, 7 header + length.
  task automatic hdr3(input logic [55:0] len);
    beat_t b;
    for (int i = 0; i < 8; i++) b[i] = (i < 3) ? wd(8'h02, 56'(i+1)) : wd(8'h01, 56'(i+1));
    send(b, 1);
    for (int i = 0; i < 8; i++) b[i] = wd(8'h01, 56'(i+9));
    b[5] = wd(8'h7F, 56'h55);
    send(b, 1);
    for (int i = 0; i < 8; i++) b[i] = (i < 7) ? wd(8'h01, 56'(i+17)) : wd(8'h00, len);
    send(b, 1);
  endtask

  beat_t b;

  initial begin
    rst_n = 0; d = '0; d_valid = 0;
    #1;
    chk("rst_dest", 64'(dest), 64'h0);
    chk("rst_outs", {52'h0, dest_valid, sof, eof, frame, hdr_valid}, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    idle(1);

    // Frame A: length 27
    for (int i = 0; i < 8; i++) b[i] = (i < 3) ? wd(8'h02, 56'(i+1)) : wd(8'h01, 56'(i+1));
    send(b, 1);
    chk("A_sof", 64'(sof), 64'h1);
    chk("A_dest", 64'(dest), 64'h1);
    chk("A_dv", 64'(dest_valid), 64'h1);
    chk("A_hdr1", 64'(hdr_valid), 64'hFF);
    for (int i = 0; i < 8; i++) b[i] = wd(8'h01, 56'(i+9));
    send(b, 1);
    chk("A_hdr2", 64'(hdr_valid), 64'hFF);
    for (int i = 0; i < 8; i++) b[i] = (i < 7) ? wd(8'h01, 56'(i+17)) : wd(8'h00, 56'd27);
    send(b, 1);
    chk("A_hdr3", 64'(hdr_valid), 64'hFF);
    chk("A_pld3", 64'(pld_valid), 64'h00);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 8; i++) b[i] = wd(8'h03, 56'(k*8+i+1));
      send(b, 1);
      chk("A_pldfull", 64'(pld_valid), 64'hFF);
      chk("A_frame", 64'(frame), 64'h1);
    end
    for (int i = 0; i < 8; i++) b[i] = wd(8'h03, 56'(25+i));
    send(b, 1);
    chk("A_pld7", 64'(pld_valid), 64'h07);
    chk("A_eof", 64'(eof), 64'h1);

    // Frame B back-to-back: length 10
    hdr3(56'd10);
    chk("B_hdr", 64'(hdr_valid), 64'hFF);
    for (int i = 0; i < 8; i++) b[i] = wd(8'h03, 56'(i));
    send(b, 1);
    chk("B_pld", 64'(pld_valid), 64'hFF);
    send(b, 1);
    chk("B_pld_last", 64'(pld_valid), 64'h03);
    chk("B_eof", 64'(eof), 64'h1);
    idle(1);

    // Single beat: length word at lane 3, length 2, no route word
    for (int i = 0; i < 8; i++) b[i] = wd(8'h01, 56'(i));
    b[3] = wd(8'h00, 56'd2);
    b[4] = wd(8'h03, 56'hA);
    b[5] = wd(8'h03, 56'hB);
    send(b, 1);
    chk("S_hdr", 64'(hdr_valid), 64'h0F);
    chk("S_pld", 64'(pld_valid), 64'h30);
    chk("S_sofeof", {62'h0, sof, eof}, 64'h3);
    chk("S_nodv", 64'(dest_valid), 64'h0);
    chk("S_dest_hold", 64'(dest), 64'h1);

    // Gap mid-payload: route 7, length 12 at lane 7
    for (int i = 0; i < 8; i++) b[i] = wd(8'h01, 56'(i));
    b[0] = wd(8'h02, 56'd7);
    b[7] = wd(8'h00, 56'd12);
    send(b, 1);
    for (int i = 0; i < 8; i++) b[i] = wd(8'h03, 56'(i));
    send(b, 1);
    idle(3);
    chk("G_gap", {54'h0, frame, hdr_valid, pld_valid[0]}, 64'h0);
    send(b, 1);
    chk("G_pld", 64'(pld_valid), 64'h0F);
    chk("G_eof", 64'(eof), 64'h1);

    // Two route words: DEST takes the first
    for (int i = 0; i < 8; i++) b[i] = wd(8'h03, 56'(i));
    b[0] = wd(8'h02, 56'd5);
    b[1] = wd(8'h02, 56'd9);
    b[2] = wd(8'h00, 56'd1);
    send(b, 1);
    chk("R_dest", 64'(dest), 64'h5);
    chk("R_dv", 64'(dest_valid), 64'h1);
    chk("R_hdr", 64'(hdr_valid), 64'h07);
    chk("R_pld", 64'(pld_valid), 64'h08);
    idle(1);
    chk("R_dv_once", 64'(dest_valid), 64'h0);
    chk("R_dest_hold", 64'(dest), 64'h5);

    // Length value above LENW bits: only low 16 bits (=1) count
    for (int i = 0; i < 8; i++) b[i] = wd(8'h03, 56'(i));
    b[0] = wd(8'h00, {40'hABC, 16'd1});
    send(b, 1);
    chk("L_pld", 64'(pld_valid), 64'h02);
    chk("L_eof", 64'(eof), 64'h1);

    // Reset mid-payload, then fresh frame
    hdr3(56'd20);
    for (int i = 0; i < 8; i++) b[i] = wd(8'h03, 56'(i));
    send(b, 1);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("X_rst_dest", 64'(dest), 64'h0);
    chk("X_rst_pld", 64'(pld_valid), 64'h0);
    d_valid = 1;
    repeat (2) @(negedge clk);
    rst_n = 1;
    d_valid = 0;
    for (int i = 0; i < 8; i++) b[i] = wd(8'h03, 56'(i));
    b[0] = wd(8'h02, 56'h33);
    b[1] = wd(8'h00, 56'd0);
    send(b, 1);
    chk("X_sof", {62'h0, sof, eof}, 64'h3);
    chk("X_hdr", 64'(hdr_valid), 64'h03);
    chk("X_dest", 64'(dest), 64'h33);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/routex_sink_parser.md
Name: routex_sink_parser

Overview:
- Terminating (sink) endpoint of the routex on-chip network.
- Accepts 8-lane x 64-bit beats and delineates each frame into route words, header words, a length word and payload.
- Reports per-lane header/payload qualifiers, start/end of frame and the frame's destination word to downstream consumers.

Parameters:
LANES, 8, words per beat
W, 64, word width; bits [W-1:W-8] are the tag, [W-9:0] the value
LENW, 16, payload-length counter width; the low LENW bits of the length value are used

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-low reset
D  in  LANES x W  beat data; lane 0 is the first word in order
D_VALID  in  1  beat qualifier
DEST  out  W-8  value of the frame's first route word
DEST_VALID  out  1  one-cycle pulse when DEST updates
SOF  out  1  first beat of a frame
EOF  out  1  last beat of a frame
FRAME  out  1  beat belongs to a frame
HDR_VALID  out  LANES  per-lane flag: header-section word
PLD_VALID  out  LANES  per-lane flag: payload word

Behaviour:
- Reset (RST low, async): state=HEAD_IDLE, all outputs 0, DEST=0, counters 0.
- Only beats with D_VALID=1 are processed. D_VALID=0 stalls: state is held and per-beat outputs are 0 in the following cycle.
- Outputs are registered: one-cycle latency from the accepted beat.
- Word classification in header phase, per lane in order 0..7:
  - tag 8'h02: route word.
  - tag 8'h00: length word; value = payload word count; ends the header.
  - any other tag (8'h01 and reserved values): header word.
- States:
  - IDLE: no frame open. A valid beat opens a frame at lane 0 and enters HEAD. That beat asserts SOF.
  - HEAD: route and header words accumulate, possibly across several beats, until the length word.
    - Lanes after the length word in the same beat are payload, up to the count.
    - Length 0: EOF on that beat; return to IDLE.
    - Otherwise enter PLD with REM = length minus the payload lanes already consumed.
  - PLD: each valid beat consumes min(REM,8) lanes starting at lane 0.
    - When REM reaches 0: EOF on that beat; return to IDLE.
    - Lanes after the final payload word are ignored.
- The next frame starts at lane 0 of the next valid beat. Back-to-back frames are allowed.
- Per-beat outputs:
  - HDR_VALID[i]=1 for route, header and length words.
  - PLD_VALID[i]=1 for payload words.
  - FRAME=1 for every beat of the frame.
  - SOF and EOF may both be 1 on a single-beat frame.
- DEST:
  - Loaded with the value bits of the first route word of each frame; DEST_VALID pulses with that beat's outputs.
  - Later route words in the same frame do not change DEST.
  - DEST holds until the next frame's first route word.
  - A frame with no route word leaves DEST unchanged, with no DEST_VALID.
- Reset asserted mid-frame discards the frame immediately.

Test Plan:
- Frame A, 7 consecutive valid beats:
  - Stimulus: beat1 lanes0-2 {02,1..3}, lanes3-7 {01,4..8}; beat2 all {01,..}; beat3 lanes0-6 {01,..}, lane7 length 27; beats4-6 payload 1..24; beat7 lanes0-2 = 25..27.
  - Response: SOF, DEST=56'h1 and DEST_VALID on beat1's output cycle.
  - HDR_VALID=FF for beats1-3; PLD_VALID=00 on beat3.
  - PLD_VALID=FF for beats4-6; beat7 PLD_VALID=07 with EOF.
  - FRAME high for all 7 output cycles.
- Frame B:
  - Stimulus: same header pattern with lane7 length 10; then one full beat; then lanes0-1.
  - Response: HDR_VALID FF, then PLD_VALID FF, then PLD_VALID 03 with EOF.
- Length word at lane 3, length 2, in a single beat -> HDR_VALID=0F, PLD_VALID=30, SOF and EOF together.
- D_VALID low for 3 cycles mid-payload -> zero outputs during the gap; payload count resumes correctly and EOF lands on the right lane.
- Frame with two route words (values 5, 9) -> DEST=5, single DEST_VALID pulse.
- Assert RST mid-payload, then send a fresh frame -> outputs 0 during reset; the new frame parses from HEAD with SOF.
